// File: rtl/issue_scheduler_pkg.sv
// Shared types and encodings for the dual-issue decode-to-execute scheduler.
package issue_scheduler_pkg;
  typedef enum logic {ST_NORMAL = 1'b0, ST_SPLIT = 1'b1} issue_state_e;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC4 = 2'b10;

  localparam logic [1:0] LOAD_SRC_ENC = RES_MEM;
  localparam int         NUM_SRC      = 4;  // Rs1, Rs2 (lane1), Rs4, Rs5 (lane2)
endpackage

// File: rtl/issue_scheduler_hazard_compare.sv
// Pure combinational load-use and intra-pair hazard detection.
module hazard_compare
  import issue_scheduler_pkg::*;
#(
  parameter logic [1:0] LOAD_SRC  = LOAD_SRC_ENC,
  parameter int         NUM_LANES = 2
) (
  input  logic [NUM_LANES-1:0]          reg_write_e,
  input  logic [NUM_LANES-1:0][1:0]     result_src_e,
  input  logic [NUM_LANES-1:0][4:0]     rd_e,
  input  logic [NUM_SRC-1:0][4:0]       rs_d,
  input  logic [NUM_SRC-1:0]            use_rs_d,
  input  logic                          reg_write_d1,
  input  logic                          reg_write_d2,
  input  logic [4:0]                    rd_d1,
  input  logic [4:0]                    rd_d2,
  input  logic                          mem_acc_d1,
  input  logic                          mem_acc_d2,
  output logic                          lu_any,
  output logic                          lu_lane2,
  output logic                          pair_haz
);
  logic [NUM_LANES-1:0] load_e;
  logic [NUM_SRC-1:0]   hit;

  for (genvar i = 0; i < NUM_LANES; i++) begin : g_load
    assign load_e[i] = reg_write_e[i] && (result_src_e[i] == LOAD_SRC) && (rd_e[i] != 5'd0);
  end

  for (genvar j = 0; j < NUM_SRC; j++) begin : g_src
    logic [NUM_LANES-1:0] m;
    for (genvar i = 0; i < NUM_LANES; i++) begin : g_ln
      assign m[i] = load_e[i] && (rs_d[j] == rd_e[i]);
    end
    assign hit[j] = use_rs_d[j] && (rs_d[j] != 5'd0) && (|m);
  end

  assign lu_any   = |hit;
  assign lu_lane2 = |hit[3:2];

  // lane2 cannot see lane1's result in the same cycle, nor can the pair share the memory port
  assign pair_haz = (reg_write_d1 && (rd_d1 != 5'd0) &&
                     ((use_rs_d[2] && rs_d[2] == rd_d1) ||
                      (use_rs_d[3] && rs_d[3] == rd_d1) ||
                      (reg_write_d2 && rd_d2 == rd_d1)))
                    || (mem_acc_d1 && mem_acc_d2);
endmodule

// File: rtl/issue_scheduler.sv
// Dual-issue decode-to-execute control: pair/split issue, load-use stall, flush, perf counters.
module issue_scheduler
  import issue_scheduler_pkg::*;
#(
  parameter logic [1:0] LOAD_SRC = LOAD_SRC_ENC,
  parameter int         CNT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             RegWriteD1,
  input  logic             RegWriteD2,
  input  logic [4:0]       RdD1,
  input  logic [4:0]       RdD2,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs4D,
  input  logic [4:0]       Rs5D,
  input  logic             UseRs1D,
  input  logic             UseRs2D,
  input  logic             UseRs4D,
  input  logic             UseRs5D,
  input  logic             MemAccD1,
  input  logic             MemAccD2,
  input  logic             RegWriteE1,
  input  logic             RegWriteE2,
  input  logic [1:0]       ResultSrcE1,
  input  logic [1:0]       ResultSrcE2,
  input  logic [4:0]       RdE1,
  input  logic [4:0]       RdE2,
  input  logic             PCSrcE,
  output logic             StallF,
  output logic             StallD,
  output logic             FlushD,
  output logic             en1,
  output logic             en2,
  output logic             rst1,
  output logic             rst2,
  output logic             SplitD,
  output logic [CNT_W-1:0] StallCnt,
  output logic [CNT_W-1:0] SplitCnt,
  output logic [CNT_W-1:0] FlushCnt
);
  issue_state_e state, nxt;
  logic lu_any, lu_lane2, pair_haz;
  logic stall_ev, split_ev, flush_ev;

  hazard_compare #(.LOAD_SRC(LOAD_SRC), .NUM_LANES(2)) u_haz (
    .reg_write_e  ({RegWriteE2, RegWriteE1}),
    .result_src_e ({ResultSrcE2, ResultSrcE1}),
    .rd_e         ({RdE2, RdE1}),
    .rs_d         ({Rs5D, Rs4D, Rs2D, Rs1D}),
    .use_rs_d     ({UseRs5D, UseRs4D, UseRs2D, UseRs1D}),
    .reg_write_d1 (RegWriteD1),
    .reg_write_d2 (RegWriteD2),
    .rd_d1        (RdD1),
    .rd_d2        (RdD2),
    .mem_acc_d1   (MemAccD1),
    .mem_acc_d2   (MemAccD2),
    .lu_any       (lu_any),
    .lu_lane2     (lu_lane2),
    .pair_haz     (pair_haz)
  );

  // Default is a full bubble; each branch only opens what it issues.
  always_comb begin
    StallF   = 1'b0;
    StallD   = 1'b0;
    FlushD   = 1'b0;
    en1      = 1'b0;
    en2      = 1'b0;
    rst1     = 1'b1;
    rst2     = 1'b1;
    SplitD   = (state == ST_SPLIT) && !rst;
    nxt      = state;
    stall_ev = 1'b0;
    split_ev = 1'b0;
    flush_ev = 1'b0;
    if (rst) begin
      nxt = ST_NORMAL;
    end else if (PCSrcE) begin
      FlushD   = 1'b1;
      nxt      = ST_NORMAL;
      flush_ev = 1'b1;
    end else if (state == ST_NORMAL) begin
      if (lu_any) begin
        StallF   = 1'b1;
        StallD   = 1'b1;
        stall_ev = 1'b1;
      end else if (pair_haz) begin
        en1      = 1'b1;
        rst1     = 1'b0;
        StallF   = 1'b1;
        StallD   = 1'b1;
        nxt      = ST_SPLIT;
        split_ev = 1'b1;
      end else begin
        en1  = 1'b1;
        en2  = 1'b1;
        rst1 = 1'b0;
        rst2 = 1'b0;
      end
    end else begin
      if (lu_lane2) begin
        StallF   = 1'b1;
        StallD   = 1'b1;
        stall_ev = 1'b1;
      end else begin
        en2  = 1'b1;
        rst2 = 1'b0;
        nxt  = ST_NORMAL;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_NORMAL;
      StallCnt <= '0;
      SplitCnt <= '0;
      FlushCnt <= '0;
    end else begin
      state <= nxt;
      if (stall_ev && !(&StallCnt)) StallCnt <= StallCnt + 1'b1;
      if (split_ev && !(&SplitCnt)) SplitCnt <= SplitCnt + 1'b1;
      if (flush_ev && !(&FlushCnt)) FlushCnt <= FlushCnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_issue_scheduler.sv
// Directed plus randomized check of issue_scheduler against a set-based reference model.
module tb_issue_scheduler;
  localparam int CNT_W = 4;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  logic rst;
  logic RegWriteD1, RegWriteD2, MemAccD1, MemAccD2;
  logic [4:0] RdD1, RdD2, Rs1D, Rs2D, Rs4D, Rs5D, RdE1, RdE2;
  logic UseRs1D, UseRs2D, UseRs4D, UseRs5D;
  logic RegWriteE1, RegWriteE2, PCSrcE;
  logic [1:0] ResultSrcE1, ResultSrcE2;
  logic StallF, StallD, FlushD, en1, en2, rst1, rst2, SplitD;
  logic [CNT_W-1:0] StallCnt, SplitCnt, FlushCnt;

  int checks = 0;
  int failures = 0;

  // reference state
  bit m_split;
  int m_stall, m_splitc, m_flush;
  bit e_sf, e_sd, e_fd, e_en1, e_en2, e_r1, e_r2, e_spl;

  always #5 clk = ~clk;

  issue_scheduler #(.LOAD_SRC(2'b01), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .RegWriteD1(RegWriteD1), .RegWriteD2(RegWriteD2), .RdD1(RdD1), .RdD2(RdD2),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs4D(Rs4D), .Rs5D(Rs5D),
    .UseRs1D(UseRs1D), .UseRs2D(UseRs2D), .UseRs4D(UseRs4D), .UseRs5D(UseRs5D),
    .MemAccD1(MemAccD1), .MemAccD2(MemAccD2),
    .RegWriteE1(RegWriteE1), .RegWriteE2(RegWriteE2),
    .ResultSrcE1(ResultSrcE1), .ResultSrcE2(ResultSrcE2), .RdE1(RdE1), .RdE2(RdE2),
    .PCSrcE(PCSrcE), .StallF(StallF), .StallD(StallD), .FlushD(FlushD),
    .en1(en1), .en2(en2), .rst1(rst1), .rst2(rst2), .SplitD(SplitD),
    .StallCnt(StallCnt), .SplitCnt(SplitCnt), .FlushCnt(FlushCnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Registers currently being loaded by the execute stage (r0 excluded).
  function automatic bit reads_load(input logic [4:0] s, input logic u);
    logic [4:0] loads[$];
    if (RegWriteE1 && ResultSrcE1 == 2'b01 && RdE1 != 0) loads.push_back(RdE1);
    if (RegWriteE2 && ResultSrcE2 == 2'b01 && RdE2 != 0) loads.push_back(RdE2);
    if (!u || s == 0) return 1'b0;
    foreach (loads[k]) if (loads[k] == s) return 1'b1;
    return 1'b0;
  endfunction

  function automatic bit pair_conflict();
    logic [4:0] lane2_touch[$];
    if (MemAccD1 && MemAccD2) return 1'b1;
    if (!RegWriteD1 || RdD1 == 0) return 1'b0;
    if (UseRs4D) lane2_touch.push_back(Rs4D);
    if (UseRs5D) lane2_touch.push_back(Rs5D);
    if (RegWriteD2) lane2_touch.push_back(RdD2);
    foreach (lane2_touch[k]) if (lane2_touch[k] == RdD1) return 1'b1;
    return 1'b0;
  endfunction

  function automatic int sat(input int v);
    return (v >= CMAX) ? CMAX : v + 1;
  endfunction

  task automatic clear_inputs();
    {RegWriteD1, RegWriteD2, MemAccD1, MemAccD2} = '0;
    {RdD1, RdD2, Rs1D, Rs2D, Rs4D, Rs5D, RdE1, RdE2} = '0;
    {UseRs1D, UseRs2D, UseRs4D, UseRs5D} = '0;
    {RegWriteE1, RegWriteE2, PCSrcE} = '0;
    ResultSrcE1 = 2'b00;
    ResultSrcE2 = 2'b00;
    rst = 1'b0;
  endtask

  task automatic rand_inputs();
    RegWriteD1 = 1'($urandom); RegWriteD2 = 1'($urandom);
    MemAccD1 = ($urandom_range(0, 3) == 0); MemAccD2 = ($urandom_range(0, 3) == 0);
    RdD1 = 5'($urandom_range(0, 3)); RdD2 = 5'($urandom_range(0, 3));
    Rs1D = 5'($urandom_range(0, 3)); Rs2D = 5'($urandom_range(0, 3));
    Rs4D = 5'($urandom_range(0, 3)); Rs5D = 5'($urandom_range(0, 3));
    UseRs1D = 1'($urandom); UseRs2D = 1'($urandom);
    UseRs4D = 1'($urandom); UseRs5D = 1'($urandom);
    RegWriteE1 = 1'($urandom); RegWriteE2 = 1'($urandom);
    ResultSrcE1 = 2'($urandom); ResultSrcE2 = 2'($urandom);
    RdE1 = 5'($urandom_range(0, 3)); RdE2 = 5'($urandom_range(0, 3));
    PCSrcE = ($urandom_range(0, 7) == 0);
    rst = ($urandom_range(0, 31) == 0);
  endtask

  // One clock: compute expected outputs, compare mid-cycle, then advance the model.
  task automatic run_cycle(input bit do_check);
    bit lu_all, lu_l2, ph;
    lu_all = reads_load(Rs1D, UseRs1D) || reads_load(Rs2D, UseRs2D) ||
             reads_load(Rs4D, UseRs4D) || reads_load(Rs5D, UseRs5D);
    lu_l2  = reads_load(Rs4D, UseRs4D) || reads_load(Rs5D, UseRs5D);
    ph     = pair_conflict();
    {e_sf, e_sd, e_fd, e_en1, e_en2} = '0;
    {e_r1, e_r2} = 2'b11;
    e_spl = m_split && !rst;
    if (rst) ;
    else if (PCSrcE) e_fd = 1;
    else if (!m_split) begin
      if (lu_all) {e_sf, e_sd} = 2'b11;
      else if (ph) begin e_en1 = 1; e_r1 = 0; {e_sf, e_sd} = 2'b11; end
      else begin {e_en1, e_en2} = 2'b11; {e_r1, e_r2} = 2'b00; end
    end else begin
      if (lu_l2) {e_sf, e_sd} = 2'b11;
      else begin e_en2 = 1; e_r2 = 0; end
    end
    @(negedge clk);
    #1;
    if (do_check) begin
      chk("ctl", {24'd0, StallF, StallD, FlushD, en1, en2, rst1, rst2, SplitD},
                 {24'd0, e_sf, e_sd, e_fd, e_en1, e_en2, e_r1, e_r2, e_spl});
      chk("StallCnt", 32'(StallCnt), 32'(m_stall));
      chk("SplitCnt", 32'(SplitCnt), 32'(m_splitc));
      chk("FlushCnt", 32'(FlushCnt), 32'(m_flush));
    end
    if (rst) begin m_split = 0; m_stall = 0; m_splitc = 0; m_flush = 0; end
    else if (PCSrcE) begin m_split = 0; m_flush = sat(m_flush); end
    else if (!m_split) begin
      if (lu_all) m_stall = sat(m_stall);
      else if (ph) begin m_split = 1; m_splitc = sat(m_splitc); end
    end else begin
      if (lu_l2) m_stall = sat(m_stall);
      else m_split = 0;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clear_inputs(); rst = 1;
    run_cycle(1'b1);
    rst = 0;
  endtask

  task automatic set_split_pair();
    clear_inputs();
    RegWriteD1 = 1; RdD1 = 5; UseRs4D = 1; Rs4D = 5;
  endtask

  initial begin
    clear_inputs();
    // 1: reset with random inputs; the first cycle only settles the counters
    rand_inputs(); rst = 1; run_cycle(1'b0);
    rand_inputs(); rst = 1; run_cycle(1'b1);
    chk("rst_state_cnt", 32'(StallCnt), 32'd0);
    clear_inputs(); run_cycle(1'b1);
    chk("post_rst_issue", {30'd0, en1, en2}, 32'd3);

    // 2: same-pair RAW splits issue over two cycles
    do_reset();
    set_split_pair(); run_cycle(1'b1);
    run_cycle(1'b1);
    clear_inputs(); run_cycle(1'b1);
    chk("split_cnt_one", 32'(SplitCnt), 32'd1);

    // 3: load-use on Rs2 stalls, then the pair issues
    do_reset();
    clear_inputs(); RegWriteE2 = 1; ResultSrcE2 = 2'b01; RdE2 = 7; UseRs2D = 1; Rs2D = 7;
    run_cycle(1'b1);
    RegWriteE2 = 0; run_cycle(1'b1);
    chk("lu_stall_cnt", 32'(StallCnt), 32'd1);

    // 4: load-use against pending lane2 while split
    do_reset();
    set_split_pair(); run_cycle(1'b1);
    RegWriteE1 = 1; ResultSrcE1 = 2'b01; RdE1 = 9; UseRs5D = 1; Rs5D = 9;
    run_cycle(1'b1);
    RegWriteE1 = 0; run_cycle(1'b1);
    clear_inputs(); run_cycle(1'b1);

    // 5: flush in SPLIT, then flush beating a load-use
    do_reset();
    set_split_pair(); run_cycle(1'b1);
    PCSrcE = 1; run_cycle(1'b1);
    clear_inputs(); PCSrcE = 1; RegWriteE1 = 1; ResultSrcE1 = 2'b01; RdE1 = 3;
    UseRs1D = 1; Rs1D = 3; run_cycle(1'b1);
    chk("flush_cnt_two", 32'(FlushCnt), 32'd2);

    // 6: memory pair splits, r0 writes do not, stall counter saturates
    do_reset();
    clear_inputs(); MemAccD1 = 1; MemAccD2 = 1; run_cycle(1'b1); run_cycle(1'b1);
    clear_inputs(); RegWriteD1 = 1; RegWriteD2 = 1; run_cycle(1'b1);
    clear_inputs(); RegWriteE1 = 1; ResultSrcE1 = 2'b01; RdE1 = 4; UseRs1D = 1; Rs1D = 4;
    for (int i = 0; i < CMAX + 4; i++) run_cycle(1'b1);
    chk("stall_sat", 32'(StallCnt), 32'(CMAX));
    clear_inputs(); RegWriteE1 = 1; ResultSrcE1 = 2'b01; RdE1 = 0; UseRs1D = 1; Rs1D = 0;
    run_cycle(1'b1);

    // random phase
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      rand_inputs();
      run_cycle(1'b1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/issue_scheduler.md
Name: issue_scheduler

Overview:
Controller for the dual-issue decode-to-execute pipeline register. Each cycle it decides whether the decoded pair issues together, issues split over two cycles, stalls on a load-use hazard, or is flushed. It drives the per-lane synchronous clears and enables of that register and the fetch/decode stall and flush lines. It also keeps hazard performance counters.

Parameters:
LOAD_SRC, 2'b01, ResultSrc encoding that marks a load
CNT_W, 32, width of each performance counter

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
RegWriteD1/RegWriteD2  in  1  lane writes rd (decode)
RdD1/RdD2  in  5  destination regs (decode)
Rs1D/Rs2D/Rs4D/Rs5D  in  5  sources: lane1 uses Rs1/Rs2, lane2 uses Rs4/Rs5
UseRs1D/UseRs2D/UseRs4D/UseRs5D  in  1  source actually read
MemAccD1/MemAccD2  in  1  lane is a load or store
RegWriteE1/RegWriteE2  in  1  execute-stage write enables
ResultSrcE1/ResultSrcE2  in  2  execute-stage result select
RdE1/RdE2  in  5  execute-stage destinations
PCSrcE  in  1  taken branch/jump resolved in execute (either lane)
StallF  out  1  hold PC
StallD  out  1  hold fetch-to-decode register
FlushD  out  1  clear fetch-to-decode register
en1/en2  out  1  decode-to-execute lane enables
rst1/rst2  out  1  decode-to-execute lane clears (bubble)
SplitD  out  1  high in SPLIT state
StallCnt/SplitCnt/FlushCnt  out  CNT_W  performance counters

Behaviour:
- Definitions:
  - loadEx = RegWriteEx & (ResultSrcEx==LOAD_SRC) & (RdEx!=0).
  - lu(s, use) = use & (s!=0) & ((loadE1 & s==RdE1) | (loadE2 & s==RdE2)).
  - pairHaz = (RegWriteD1 & RdD1!=0 & ((UseRs4D & Rs4D==RdD1) | (UseRs5D & Rs5D==RdD1) | (RegWriteD2 & RdD2==RdD1))) | (MemAccD1 & MemAccD2).
- States: NORMAL, SPLIT. The state register is updated on posedge clk only.
- Priority, highest first: rst, PCSrcE, load-use, pair hazard.
- rst:
  - State goes to NORMAL. All counters go to 0.
  - While rst=1: rst1=rst2=1, en1=en2=0, StallF=StallD=FlushD=0, SplitD=0.
- PCSrcE=1, any state:
  - FlushD=1, rst1=rst2=1, en=0, StallF=StallD=0.
  - Next state NORMAL. FlushCnt+1.
  - A pending SPLIT lane2 is discarded.
- NORMAL:
  - Load-use (lu on any of the 4 sources): rst1=rst2=1, StallF=StallD=1. Stay NORMAL. StallCnt+1.
  - Else if pairHaz: en1=1, rst1=0, rst2=1, StallF=StallD=1. Go to SPLIT. SplitCnt+1.
  - Else: en1=en2=1, rst1=rst2=0, stalls 0.
- SPLIT (lane1 already in execute, lane2 pending):
  - Load-use is checked on Rs4/Rs5 only. If hit: rst1=rst2=1, StallF=StallD=1. Stay SPLIT. StallCnt+1.
  - Else: rst1=1, en2=1, rst2=0, stalls 0. Go to NORMAL.
- All control outputs are combinational from state and inputs. Decision latency is 0 cycles; the effect is seen in the register one edge later.
- Counters saturate at all-ones; they do not wrap.
- r0 never creates a hazard.
- Reset asserted mid-SPLIT abandons lane2. The first cycle after reset is NORMAL.

Decomposition:
- Shared package holds:
  - the state enum;
  - the LOAD_SRC constant;
  - the ResultSrc encodings already used by the control unit.
- Natural sub-module: hazard_compare (pure combinational lu/pairHaz). The FSM and counters stay in issue_scheduler.

Test Plan:
1. rst=1 for 2 cycles with random inputs -> rst1=rst2=1, en1=en2=0, all counters 0. Cycle after release with no hazards -> en1=en2=1.
2. RegWriteD1=1, RdD1=5, UseRs4D=1, Rs4D=5, no E loads:
   - cycle0: en1=1, rst2=1, StallF=StallD=1, SplitD=0.
   - cycle1: SplitD=1, rst1=1, en2=1, stalls 0.
   - cycle2: NORMAL. SplitCnt=1.
3. Load in E: RegWriteE2=1, ResultSrcE2=2'b01, RdE2=7, UseRs2D=1, Rs2D=7 -> rst1=rst2=1, StallF=StallD=1, StallCnt=1. Drop load next cycle -> pair issues, en1=en2=1.
4. Enter SPLIT (scenario 2), then on the SPLIT cycle set loadE1 with RdE1=9, Rs5D=9, UseRs5D=1:
   - stays SPLIT one extra cycle with StallF=1;
   - then lane2 issues;
   - StallCnt=1, SplitCnt=1.
5. PCSrcE=1 while in SPLIT -> FlushD=1, rst1=rst2=1, next state NORMAL, FlushCnt=1. PCSrcE together with a load-use hazard -> flush wins, StallF=0.
6. MemAccD1=MemAccD2=1, no register overlap -> split issue. RdD1=RdD2=0 with both writing -> no split. Preload StallCnt to all-ones via a long stall -> it holds at all-ones.
